// File: rtl/cluster_encoder_scheduler.sv
// cluster_encoder_scheduler
// Sequencer for the ping-pong priority-encoder bank behind the cluster packer.
// Owns the clock4x frame phase counter. Strobes the encoder latches in round-robin
// order and steers the output mux with sel/valid_out once each encoder's result
// has settled. A bx0 that lands at any phase other than PHASES-1 forces a resync
// and is counted as a misalignment.
module cluster_encoder_scheduler #(
  parameter int PHASES      = 8,
  parameter int N_ENC       = 2,
  parameter int ENC_LATENCY = 4,
  parameter int SEL_W       = 1
) (
  input  logic                       clock4x,
  input  logic                       global_reset,
  input  logic                       enable,
  input  logic                       bx0,
  input  logic                       err_clr,
  output logic [$clog2(PHASES)-1:0]  phase_out,
  output logic [N_ENC-1:0]           latch_out,
  output logic [SEL_W-1:0]           sel,
  output logic                       valid_out,
  output logic                       resync_err,
  output logic [7:0]                 misalign_cnt
);

  localparam int PH_W = $clog2(PHASES);
  localparam int SLOT = PHASES / N_ENC;

  // One delay-line entry: a slot boundary, the encoder it belongs to, and
  // whether that encoder was really strobed in that slot.
  typedef struct packed {
    logic             tick;
    logic [SEL_W-1:0] idx;
    logic             strobed;
  } dl_t;

  logic             misaligned;
  logic [PH_W-1:0]  phase_nxt;
  logic [N_ENC-1:0] latch_nxt;
  logic [SEL_W-1:0] cur_idx;
  dl_t              cur;
  dl_t              emerge;

  // A bx0 is only legal on the last phase of the frame; anywhere else it resyncs.
  assign misaligned = bx0 && (phase_out != PH_W'(PHASES - 1));

  // Next phase: natural wrap (PHASES is a power of 2) or forced to 0 on resync.
  always_comb begin
    phase_nxt = phase_out + PH_W'(1);
    if (misaligned) begin
      phase_nxt = '0;
    end
  end

  // Registered strobes: the bit for encoder k fires when the coming phase is k*SLOT.
  always_comb begin
    latch_nxt = '0;
    for (int k = 0; k < N_ENC; k++) begin
      if (enable && (int'(phase_nxt) == k * SLOT)) begin
        latch_nxt[k] = 1'b1;
      end
    end
  end

  // Entry describing the current cycle, pushed into the delay line.
  always_comb begin
    cur_idx     = SEL_W'(int'(phase_out) / SLOT);
    cur.tick    = ((int'(phase_out) % SLOT) == 0);
    cur.idx     = cur_idx;
    cur.strobed = latch_out[cur_idx];
  end

  // The sel/valid register is the last stage, so ENC_LATENCY-1 pipeline
  // registers sit in front of it; with a latency of 1 the entry feeds it directly.
  generate
    if (ENC_LATENCY == 1) begin : g_no_dl
      assign emerge = cur;
    end else begin : g_dl
      dl_t dl_q [ENC_LATENCY-1];

      // Shift register of pending slot results; a resync discards all of them.
      always_ff @(posedge clock4x) begin
        if (global_reset || misaligned) begin
          for (int i = 0; i < ENC_LATENCY - 1; i++) begin
            dl_q[i] <= '0;
          end
        end else begin
          dl_q[0] <= cur;
          for (int i = 1; i < ENC_LATENCY - 1; i++) begin
            dl_q[i] <= dl_q[i-1];
          end
        end
      end

      assign emerge = dl_q[ENC_LATENCY-2];
    end
  endgenerate

  // Phase counter and latch strobes.
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      phase_out <= PH_W'(PHASES - 1);
      latch_out <= '0;
    end else begin
      phase_out <= phase_nxt;
      latch_out <= latch_nxt;
    end
  end

  // Output mux select: follows each tick leaving the delay line, held between ticks.
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      sel       <= '0;
      valid_out <= 1'b0;
    end else if (misaligned) begin
      valid_out <= 1'b0;
    end else if (emerge.tick) begin
      sel       <= emerge.idx;
      valid_out <= emerge.strobed;
    end
  end

  // Sticky misalignment flag and saturating event counter.
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      resync_err   <= 1'b0;
      misalign_cnt <= 8'd0;
    end else if (misaligned) begin
      resync_err <= 1'b1;
      if (err_clr) begin
        misalign_cnt <= 8'd1;
      end else if (misalign_cnt != 8'hFF) begin
        misalign_cnt <= misalign_cnt + 8'd1;
      end
    end else if (err_clr) begin
      resync_err   <= 1'b0;
      misalign_cnt <= 8'd0;
    end
  end

endmodule
